// File: rtl/pwm_dac_pkg.sv
// Shared constants for the PWM DAC and the matching ADC input mux.
package pwm_dac_pkg;

  localparam int DAC_WIDTH  = 10;
  localparam int DAC_PERIOD = 1 << DAC_WIDTH;

  // Channel select encoding. The ADC input mux uses the same values.
  localparam logic CH_ONE = 1'b0;
  localparam logic CH_TWO = 1'b1;

endpackage : pwm_dac_pkg

// File: rtl/pwm_dac_if.sv
// Valid/ready code-load bus into the PWM DAC.
interface pwm_dac_if
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH = DAC_WIDTH
) ();

  logic             load_valid;
  logic             load_ready;
  logic             load_channel;
  logic [WIDTH-1:0] load_code;

  modport master (
    output load_valid,
    output load_channel,
    output load_code,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_channel,
    input  load_code,
    output load_ready
  );

endinterface : pwm_dac_if

// File: rtl/pwm_dac_channel.sv
// One PWM channel: a one-deep pending slot, the active code and the
// registered comparator that produces the PWM stream.
module pwm_dac_channel
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH = DAC_WIDTH
) (
  input  logic             clk,
  input  logic             restart_n,
  input  logic             i_enable,
  input  logic             i_accept,
  input  logic             i_apply,
  input  logic [WIDTH-1:0] i_code,
  input  logic [WIDTH-1:0] i_counter,
  output logic             o_pending_full,
  output logic [WIDTH-1:0] o_active_code,
  output logic             o_dac_out
);

  logic [WIDTH-1:0] r_pending_code;
  logic             r_pending_full;
  logic [WIDTH-1:0] r_active_code;
  logic             r_dac_out;

  // Code storage: promote pending at a boundary (or when idling), and take
  // accepted loads into pending while running or straight to active when idle.
  // An accept only happens with the slot empty, so the two never collide.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      r_pending_code <= '0;
      r_pending_full <= 1'b0;
      r_active_code  <= '0;
    end else begin
      if (i_apply && r_pending_full) begin
        r_active_code  <= r_pending_code;
        r_pending_full <= 1'b0;
      end
      if (i_accept) begin
        if (i_enable) begin
          r_pending_code <= i_code;
          r_pending_full <= 1'b1;
        end else begin
          r_active_code  <= i_code;
        end
      end
    end
  end

  // PWM compare, registered; lags the counter by one cycle.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      r_dac_out <= 1'b0;
    end else begin
      r_dac_out <= i_enable && (i_counter < r_active_code);
    end
  end

  assign o_pending_full = r_pending_full;
  assign o_active_code  = r_active_code;
  assign o_dac_out      = r_dac_out;

endmodule : pwm_dac_channel

// File: rtl/pwm_dac.sv
// Dual-channel PWM DAC: shared period counter, period_start pulse, load
// demux to the two channels and the per-channel ready mux.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH = DAC_WIDTH
) (
  input  logic             clk,
  input  logic             restart_n,
  input  logic             enable,
  pwm_dac_if.slave         load_if,
  output logic             dac_out_one,
  output logic             dac_out_two,
  output logic [WIDTH-1:0] active_code_one,
  output logic [WIDTH-1:0] active_code_two,
  output logic             period_start
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_counter;
  logic             r_period_start;
  logic             w_boundary;
  logic             w_apply;
  logic             w_accept;
  logic             w_accept_one;
  logic             w_accept_two;
  logic             w_full_one;
  logic             w_full_two;

  assign w_boundary   = enable && (r_counter == CNT_MAX);
  // Disabling flushes pending codes into active on the first idle edge.
  assign w_apply      = w_boundary || !enable;
  assign w_accept     = load_if.load_valid && load_if.load_ready;
  assign w_accept_one = w_accept && (load_if.load_channel == CH_ONE);
  assign w_accept_two = w_accept && (load_if.load_channel == CH_TWO);

  assign load_if.load_ready = restart_n &&
    !((load_if.load_channel == CH_ONE) ? w_full_one : w_full_two);

  // Period counter: free-runs while enabled, parked at 0 while idle.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      r_counter <= '0;
    end else if (!enable) begin
      r_counter <= '0;
    end else begin
      r_counter <= r_counter + 1'b1;
    end
  end

  // Period start pulse, aligned with counter = 0 of each wrapped period.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
    end
  end

  pwm_dac_channel #(.WIDTH(WIDTH)) u_ch_one (
    .clk            (clk),
    .restart_n      (restart_n),
    .i_enable       (enable),
    .i_accept       (w_accept_one),
    .i_apply        (w_apply),
    .i_code         (load_if.load_code),
    .i_counter      (r_counter),
    .o_pending_full (w_full_one),
    .o_active_code  (active_code_one),
    .o_dac_out      (dac_out_one)
  );

  pwm_dac_channel #(.WIDTH(WIDTH)) u_ch_two (
    .clk            (clk),
    .restart_n      (restart_n),
    .i_enable       (enable),
    .i_accept       (w_accept_two),
    .i_apply        (w_apply),
    .i_code         (load_if.load_code),
    .i_counter      (r_counter),
    .o_pending_full (w_full_two),
    .o_active_code  (active_code_two),
    .o_dac_out      (dac_out_two)
  );

  assign period_start = r_period_start;

endmodule : pwm_dac

// File: doc/pwm_dac.md
Name: pwm_dac

Overview:
Dual-channel pulse-width-modulation DAC. It is the output-direction counterpart of the successive-approximation converter.
- Takes 10-bit digital codes over a valid/ready load interface.
- Produces one 1-bit PWM stream per channel, with duty cycle = code / 2^WIDTH.
- Each channel has a one-deep pending buffer. New codes take effect only at a PWM period boundary, so no period is ever truncated.

Parameters:
- WIDTH, 10, code width and period counter width; period = 2^WIDTH cycles.

Ports:
- clk  input  1  clock.
- restart_n  input  1  asynchronous active-low reset.
- enable  input  1  run PWM; low = idle (counter held at 0, outputs low).
- load_valid  input  1  load request.
- load_ready  output  1  load can be accepted this cycle.
- load_channel  input  1  0 = channel one, 1 = channel two.
- load_code  input  WIDTH  code to load.
- dac_out_one  output  1  PWM stream, channel one.
- dac_out_two  output  1  PWM stream, channel two.
- active_code_one  output  WIDTH  code currently driving channel one.
- active_code_two  output  WIDTH  code currently driving channel two.
- period_start  output  1  one-cycle pulse when a new period begins.

Behaviour:
- Reset (restart_n low, asynchronous):
  - counter, active codes, pending codes and pending flags clear to 0.
  - dac_out_one, dac_out_two and period_start clear to 0.
  - load_ready is 0 while restart_n is low.
- Counter:
  - When enable = 1, counter increments by 1 every cycle and wraps from 2^WIDTH-1 to 0.
  - When enable = 0, counter is forced to 0 on the next edge.
- Output compare:
  - dac_out_x <= enable && (counter < active_code_x), registered.
  - The output therefore lags the counter by one cycle.
  - Code 0 gives a constant low output.
  - Code 2^WIDTH-1 gives a high output for 2^WIDTH-1 of every 2^WIDTH cycles; it is never constantly high.
- period_start:
  - Registered pulse, asserted in the cycle after the counter is at 2^WIDTH-1 with enable = 1.
  - It coincides with counter = 0 of the new period.
- Load handshake:
  - load_ready = restart_n && !pending_full[load_channel]. This is combinational from the registered flag and load_channel.
  - A load is accepted when load_valid && load_ready on a clk edge.
  - On acceptance with enable = 1: pending_code[ch] <= load_code, pending_full[ch] <= 1.
  - On acceptance with enable = 0: active_code[ch] <= load_code directly (bypass); the pending flag is unaffected.
  - Once a load is accepted, load_valid and load_code may change in the next cycle.
- Period boundary (enable = 1 and counter == 2^WIDTH-1):
  - For each channel with pending_full set: active_code <= pending_code and pending_full <= 0.
  - The new code governs the output from counter = 0 onward.
- Simultaneous accept and boundary, same channel:
  - If pending is empty, ready is high and the code is written to pending. It is not applied until the next boundary, 2^WIDTH cycles later.
  - If pending is full, ready is low and nothing is accepted. ready rises the following cycle.
- Enable falling mid-period:
  - On the first edge with enable = 0, every full pending slot is transferred to active and its flag is cleared.
  - The counter goes to 0 and outputs go low one edge later.
- Enable rising:
  - The counter starts at 0, so the first period is complete.
  - period_start is not pulsed for that first period.
- Reset mid-operation: all state is lost immediately. Pending codes are discarded, not applied.
- Channels are independent. A load on one channel never alters the other channel's pending or active state.

Decomposition:
- Shared package holds:
  - DAC_WIDTH = 10.
  - DAC_PERIOD = 2^DAC_WIDTH.
  - Channel constants CH_ONE = 0 and CH_TWO = 1, shared with the ADC input mux.
- One natural sub-module, pwm_dac_channel, instantiated twice. It holds the pending register, pending flag, active register and output comparator.
- The top level owns the counter, period_start, channel demux and load_ready mux.

Test Plan:
1. Reset, enable = 1, load ch0 code 256 and ch1 code 768 while idle (enable = 0 bypass) -> active codes are 256 and 768 immediately. Over 1024 cycles, dac_out_one is high for exactly 256 cycles and dac_out_two for exactly 768.
2. Codes 0 and 1023 -> dac_out_one is never high. dac_out_two is high for 1023 cycles and low for 1 cycle each period.
3. Running with ch0 = 100, load 500 at counter = 300 -> active_code_one stays 100 until the counter wraps, then becomes 500. The high-count of the loading period is 100 and the next period's is 500. A second ch0 load before the wrap sees load_ready = 0, while a ch1 load in the same window is accepted.
4. Pending ch0 full, load_valid held high through counter = 1023 -> no acceptance at the boundary edge. Accepted the next cycle and applied one full period later. period_start pulses once per 1024 cycles.
5. Pending ch1 = 42, drop enable mid-period -> active_code_two = 42 after one edge, both outputs low, counter = 0. Re-enable -> the first full period is high for 42 cycles.
6. Assert restart_n low mid-period with pending full -> all outputs and codes are 0 immediately. After release, load_ready = 1 and the discarded pending code never appears on active_code.
